// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Byte-serial controller that shares one 8-bit synchronous RAM port between
// the instruction-fetch path and the MEM stage. An accepted access of 1, 2 or
// 4 bytes is carried out as consecutive little-endian byte transfers. Completion
// is signalled by a one-cycle ready pulse to the requester that owns the access.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   if_req / if_addr          instruction fetch request (always 4-byte read)
//   if_cancel                 abort an in-flight fetch (branch redirect)
//   if_ready / if_data        fetch completion pulse and fetched word
//   mem_req / mem_we          data access request, 1 = store
//   mem_len                   bytes minus one (0 byte, 1 half, 2/3 word)
//   mem_addr / mem_wdata      data byte address and store data
//   mem_ready / mem_rdata     data completion pulse and zero-extended load data
//   ram_addr / ram_wr         RAM byte address and write strobe
//   ram_dout / ram_din        RAM write byte and read byte (one-cycle latency)
//   busy                      controller is not idle
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_ready,
    output logic [31:0]       if_data,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,

    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Control state
    state_t            state_q, state_d;
    logic              owner_mem_q, owner_mem_d;   // 1 = MEM stage, 0 = fetch
    logic [2:0]        cnt_q, cnt_d;               // edges elapsed since acceptance
    logic [2:0]        len_q, len_d;               // access length in bytes

    // Registered outputs
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    // Datapath: latched base address and store-shift / load-assembly word
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       shift_q, shift_d;

    function automatic logic [2:0] len_decode(input logic [1:0] len);
        case (len)
            2'd0:    len_decode = 3'd1;
            2'd1:    len_decode = 3'd2;
            default: len_decode = 3'd4;   // 2 is treated as a full word
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = ram_wr_q;
        ram_dout_d  = ram_dout_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            S_IDLE: begin
                ram_wr_d = 1'b0;
                // MEM holds the older instruction, so it wins the port.
                if (mem_req) begin
                    owner_mem_d = 1'b1;
                    addr_d      = mem_addr;
                    ram_addr_d  = mem_addr;
                    cnt_d       = 3'd1;
                    len_d       = len_decode(mem_len);
                    if (mem_we) begin
                        state_d    = S_WRITE;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                        shift_d    = {8'h00, mem_wdata[31:8]};
                    end else begin
                        state_d = S_READ;
                        shift_d = '0;
                    end
                end else if (if_req) begin
                    owner_mem_d = 1'b0;
                    addr_d      = if_addr;
                    ram_addr_d  = if_addr;
                    cnt_d       = 3'd1;
                    len_d       = 3'd4;
                    state_d     = S_READ;
                    shift_d     = '0;
                end
            end

            S_READ: begin
                if (!owner_mem_q && if_cancel) begin
                    // Redirected fetch: drop it silently, address bus holds.
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q < len_q) begin
                        ram_addr_d = addr_q + ADDR_W'(cnt_q);
                    end
                    // Byte k returns two edges after its address was issued.
                    case (cnt_q)
                        3'd2:    shift_d[7:0]   = ram_din;
                        3'd3:    shift_d[15:8]  = ram_din;
                        3'd4:    shift_d[23:16] = ram_din;
                        3'd5:    shift_d[31:24] = ram_din;
                        default: ;
                    endcase
                    if (cnt_q == len_q + 3'd1) begin
                        // shift_d already holds the final byte merged in.
                        if (owner_mem_q) begin
                            mem_ready_d = 1'b1;
                            mem_rdata_d = shift_d;
                        end else begin
                            if_ready_d = 1'b1;
                            if_data_d  = shift_d;
                        end
                        state_d = S_IDLE;
                    end
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_WRITE: begin
                if (cnt_q < len_q) begin
                    ram_addr_d = addr_q + ADDR_W'(cnt_q);
                    ram_dout_d = shift_q[7:0];
                    shift_d    = {8'h00, shift_q[31:8]};
                    cnt_d      = cnt_q + 3'd1;
                end else begin
                    ram_wr_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d  = S_IDLE;
                ram_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_mem_q <= 1'b0;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'h00;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Pure datapath registers: always rewritten at acceptance, no reset needed.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        shift_q <= shift_d;
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_ready  = if_ready_q;
    assign if_data   = if_data_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != S_IDLE);

    // The write strobe only ever accompanies a store in progress.
    a_wr_only_in_write: assert property (@(posedge clk) disable iff (rst)
        ram_wr_q |-> (state_q == S_WRITE));

    // Ready pulses are raised on the transition to idle and never together.
    a_ready_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(if_ready_q && mem_ready_q));

    a_ready_in_idle: assert property (@(posedge clk) disable iff (rst)
        (if_ready_q || mem_ready_q) |-> (state_q == S_IDLE));

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic              if_ready;
    logic [31:0]       if_data;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              busy;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_cancel (if_cancel),
        .if_ready  (if_ready),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Contents of never-written locations, shared by RAM and model.
    function automatic logic [7:0] def_byte(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
    endfunction

    // Synchronous byte RAM (4 KiB window, addresses alias on bits 11:0).
    bit [7:0] ram_mem     [0:4095];
    bit       ram_written [0:4095];

    always @(posedge clk) begin
        if (ram_wr) begin
            ram_mem[ram_addr[11:0]]     <= ram_dout;
            ram_written[ram_addr[11:0]] <= 1'b1;
        end
        ram_din <= ram_written[ram_addr[11:0]] ? ram_mem[ram_addr[11:0]]
                                               : def_byte(ram_addr[11:0]);
    end

    // Free-running monitor counters
    int wr_cnt   = 0;
    int viol_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (ram_wr) wr_cnt <= wr_cnt + 1;
        if (ram_wr && !busy) viol_cnt <= viol_cnt + 1;
        if (if_ready && mem_ready) both_cnt <= both_cnt + 1;
    end

    // Reference model: a flat byte array updated per completed store.
    logic [7:0]  model_mem [0:4095];
    logic [31:0] hold_if;
    logic [31:0] hold_mem;

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] w;
        logic [31:0] ai;
        w = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            w[8*i +: 8] = model_mem[ai[11:0]];
        end
        return w;
    endfunction

    task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] d);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            model_mem[ai[11:0]] = d[8*i +: 8];
        end
    endtask

    // Issue one access starting at a negedge; returns at the negedge inside
    // the ready cycle with the request already dropped.
    task automatic run_txn(input string name, input bit is_if, input bit we,
                           input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
        int n;
        int exp_lat;
        int c;
        int w0;
        bit got;
        n       = is_if ? 4 : nbytes(len);
        exp_lat = (we && !is_if) ? n + 1 : n + 2;
        w0      = wr_cnt;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_len   = len;
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        c   = 0;
        got = 1'b0;
        while (!got && c < 20) begin
            @(posedge clk);
            #1;
            c++;
            if (is_if ? if_ready : mem_ready) got = 1'b1;
        end
        chk({name, " latency"}, c, exp_lat);
        if (is_if) hold_if = exp_data;
        else if (!we) hold_mem = exp_data;
        else model_write(addr, n, wdata);
        chk({name, " if_data"}, if_data, hold_if);
        chk({name, " mem_rdata"}, mem_rdata, hold_mem);
        chk({name, " ram_wr cycles"}, wr_cnt - w0, (we && !is_if) ? n : 0);
        @(negedge clk);
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int mem_at;
        int if_at;
        bit seen;
        int kind;
        logic [1:0]  rlen;
        logic [31:0] raddr;
        logic [31:0] rdata;

        for (int i = 0; i < 4096; i++) model_mem[i] = def_byte(12'(i));
        hold_if  = 32'h0;
        hold_mem = 32'h0;

        //             is_if we len   addr          wdata         expected
        vecs[0]  = '{1'b0, 1'b1, 2'd3, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0102, 32'h0,         32'h0000_00AD};
        vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0101, 32'h0,         32'h0000_ADBE};
        vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 32'h0000_0004, 32'h0000_0513, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0004, 32'h0,         32'h0000_0513};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0103, 32'hFFFF_FF77, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0100, 32'h0,         32'h77AD_BEEF};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0106, 32'h1234_CAFE, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 32'h0000_0104, 32'h0000_5678, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h0000_0104, 32'h0,         32'hCAFE_5678};
        vecs[12] = '{1'b0, 1'b0, 2'd1, 32'h0000_0103, 32'h0,         32'h0000_7877};

        if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
        rst = 1'b1;

        // Reset values
        #12;
        chk("reset ram_wr", ram_wr, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset ram_dout", ram_dout, 0);
        chk("reset if_ready", if_ready, 0);
        chk("reset mem_ready", mem_ready, 0);
        chk("reset if_data", if_data, 0);
        chk("reset mem_rdata", mem_rdata, 0);
        chk("reset busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back to back
        for (int i = 0; i < 13; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].is_if, vecs[i].we, vecs[i].len,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end

        // Contention: both request in the same cycle, MEM first
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h100;
        c = 0; mem_at = 0; if_at = 0;
        while (if_at == 0 && c < 30) begin
            @(posedge clk);
            #1;
            c++;
            if (mem_ready && mem_at == 0) mem_at = c;
            if (if_ready && if_at == 0) if_at = c;
            if (mem_at == c) begin
                chk("contend mem_rdata", mem_rdata, 32'h0000_00EF);
                @(negedge clk);
                mem_req = 1'b0;
            end
        end
        chk("contend mem_ready edge", mem_at, 3);
        chk("contend if_ready edge", if_at, 9);
        chk("contend if_data", if_data, 32'hCAFE_5678);
        hold_mem = 32'h0000_00EF;
        hold_if  = 32'hCAFE_5678;
        @(negedge clk);
        if_req = 1'b0;

        // Cancel a fetch at E2
        if_req = 1'b1; if_addr = 32'h80;
        @(posedge clk); #1;
        chk("cancel busy after E0", busy, 1);
        @(posedge clk);
        @(negedge clk);
        if_cancel = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        chk("cancel busy after E2", busy, 0);
        @(negedge clk);
        if_cancel = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (if_ready) seen = 1'b1;
        end
        chk("cancel no if_ready", seen, 0);
        chk("cancel if_data held", if_data, hold_if);
        @(negedge clk);
        run_txn("store 0x40", 1'b0, 1'b1, 2'd3, 32'h40, 32'h1122_3344, 32'h0);
        run_txn("fetch 0x40", 1'b1, 1'b0, 2'd0, 32'h40, 32'h0, 32'h1122_3344);

        // if_cancel during a MEM-owned load has no effect
        if_cancel = 1'b1;
        run_txn("load with cancel", 1'b0, 1'b0, 2'd3, 32'h100, 32'h0, 32'h77AD_BEEF);
        if_cancel = 1'b0;

        // Address wrap
        run_txn("wrap store", 1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("wrap ram_addr E0", ram_addr, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap ram_addr E1", ram_addr, 32'h0000_0000);
        c = 2;
        while (!mem_ready && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("wrap latency", c, 4);
        chk("wrap mem_rdata", mem_rdata, 32'h0000_1234);
        hold_mem = 32'h0000_1234;
        @(negedge clk);
        mem_req = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            kind  = $urandom_range(0, 2);
            rlen  = 2'($urandom_range(0, 3));
            rdata = $urandom;
            if ($urandom_range(0, 7) == 0) raddr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else raddr = 32'h200 + $urandom_range(0, 32'h5FF);
            if (kind == 0)
                run_txn($sformatf("rnd%0d fetch", i), 1'b1, 1'b0, 2'd0, raddr, 32'h0,
                        model_read(raddr, 4));
            else if (kind == 1)
                run_txn($sformatf("rnd%0d load", i), 1'b0, 1'b0, rlen, raddr, 32'h0,
                        model_read(raddr, nbytes(rlen)));
            else
                run_txn($sformatf("rnd%0d store", i), 1'b0, 1'b1, rlen, raddr, rdata, 32'h0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Asynchronous reset in the middle of a word store
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h180;
        mem_wdata = 32'hA5A5_A5A5;
        repeat (3) @(posedge clk);
        #1;
        chk("midwrite ram_wr before reset", ram_wr, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midwrite ram_wr", ram_wr, 0);
        chk("midwrite busy", busy, 0);
        chk("midwrite ram_addr", ram_addr, 0);
        chk("midwrite ram_dout", ram_dout, 0);
        chk("midwrite if_data", if_data, 0);
        chk("midwrite mem_rdata", mem_rdata, 0);
        chk("midwrite readies", {if_ready, mem_ready}, 0);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hold_if  = 32'h0;
        hold_mem = 32'h0;
        @(negedge clk);
        run_txn("post-reset load", 1'b0, 1'b0, 2'd3, 32'h100, 32'h0, 32'h77AD_BEEF);
        run_txn("post-reset fetch", 1'b1, 1'b0, 2'd0, 32'h4, 32'h0, 32'h0000_0513);

        repeat (2) @(negedge clk);
        chk("ram_wr outside write", viol_cnt, 0);
        chk("simultaneous readies", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller that shares the single 8-bit synchronous RAM port between the instruction-fetch path (driven by the PC register) and the MEM stage. It arbitrates between the two requesters and sequences each 1/2/4-byte access as consecutive little-endian byte transfers. It then returns a one-cycle ready pulse with the assembled word. The pipeline stalls on the requester's pending request until that pulse arrives.

## Interface
- ADDR_W, 32, width of all byte addresses
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  instruction fetch request (always 4-byte read)
- if_addr  in  ADDR_W  fetch address (PC)
- if_cancel  in  1  abort in-flight fetch (branch/jump redirect)
- if_ready  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched instruction word
- mem_req  in  1  data access request
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  bytes minus one: 0 = byte, 1 = half, 3 = word (2 treated as 3)
- mem_addr  in  ADDR_W  data byte address
- mem_wdata  in  32  store data, byte 0 = bits 7:0
- mem_ready  out  1  one-cycle pulse: load data valid / store complete
- mem_rdata  out  32  load data, zero-extended above mem_len
- ram_addr  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid the cycle after RAM samples ram_addr
- busy  out  1  controller not IDLE

## Operation
- States: IDLE, READ, WRITE. Internal: owner (IF/MEM), byte counter k, length n (1, 2 or 4), latched address, 32-bit shift/assembly register.
- Arbitration only in IDLE: mem_req wins over if_req (MEM holds the older instruction). Non-preemptive: once accepted, an access runs to completion or cancel.
- Requests must hold addr/we/len/wdata stable until their ready pulse. They must drop or change req by the edge ending the ready cycle.
- Acceptance edge E0 (IDLE, req sampled): latch request, ram_addr <= addr, k <= 0; store: ram_wr <= 1, ram_dout <= wdata[7:0].
- WRITE: at edge Ek, k = 1..n-1, ram_addr <= addr+k and ram_dout <= wdata[8k+7:8k]. At En, ram_wr <= 0, mem_ready <= 1, state <= IDLE.
- READ: ram_addr <= addr+k at Ek, k = 0..n-1. Byte k is captured from ram_din at E(k+2) into bits 8k+7:8k. At E(n+1), the ready pulse is raised for the owner, data output is updated, and state <= IDLE.
- Address arithmetic is modulo 2^ADDR_W; addr+k wraps at the top of the address space. No alignment requirement.
- if_cancel while owner = IF in READ: at the next edge go IDLE, no if_ready, ram_addr holds. if_cancel in IDLE or with owner = MEM: ignored.
- if_data/mem_rdata hold their last value between pulses.

## Timing
- Reset (async, immediate): state IDLE, ram_wr 0, ram_addr 0, ram_dout 0, if_ready 0, mem_ready 0, if_data 0, mem_rdata 0, busy 0. Reset during WRITE may leave a partial store in RAM; this is accepted.
- Load/fetch of n bytes: ready high in the cycle after E(n+1). A word fetch takes 6 cycles from the acceptance edge through the ready cycle.
- Store of n bytes: ready high in the cycle after En. A word store has 4 ram_wr cycles.
- Back-to-back: a new acceptance is possible at the edge ending a ready cycle (E(n+2) for reads, E(n+1) for writes).
- Simultaneous if_req and mem_req in IDLE: MEM served first, then IF on the next IDLE sample.
- ram_wr is never high in IDLE or READ.

## Test plan
- Word fetch: if_req, if_addr 0x00000004, RAM bytes 13 05 00 00 -> if_ready pulse after E5, if_data 0x00000513, no ram_wr.
- Store/load: mem_we 1, len 3, addr 0x100, wdata 0xDEADBEEF -> RAM 0x100..0x103 = EF BE AD DE, ready after E4. Then a byte load at 0x102 -> mem_rdata 0x000000AD.
- Contention: if_req and mem_req asserted the same cycle -> mem_ready precedes if_ready; if_ready arrives 6 cycles after the MEM ready cycle ends.
- Cancel: if_cancel asserted at E2 of a fetch -> no if_ready, busy 0 next cycle. A new fetch at 0x40 then completes correctly.
- Wrap: halfword load at 0xFFFFFFFF -> ram_addr FFFFFFFF then 00000000, mem_rdata assembled little-endian.
- Async reset asserted mid-WRITE at E2 -> ram_wr drops without waiting for a clock, all outputs at reset values, next request served normally.
